// File: rtl/ysyx_201979054_clint_pkg.sv
// ysyx_201979054_clint_pkg
//   Shared types and constants for the CLINT access bridge.
//   - Byte offsets of the CLINT registers relative to the CLINT base.
//   - clint_idx_t: CLINT word index driven on the register-block address port.
//   - req_size_t: request access size.
//   - clint_acc_state_t: bridge FSM state, also exported for debug.
//   - size_mask / size_lo_mask: byte-lane masks for a given access size.
package ysyx_201979054_clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  typedef enum logic [1:0] {
    IDX_MSIP     = 2'd0,
    IDX_MTIME    = 2'd1,
    IDX_MTIMECMP = 2'd2
  } clint_idx_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } req_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } clint_acc_state_t;

  // Data mask covering the bytes of one access of the given size.
  function automatic logic [63:0] size_mask(input req_size_t size);
    case (size)
      SZ_BYTE: size_mask = 64'h0000_0000_0000_00FF;
      SZ_HALF: size_mask = 64'h0000_0000_0000_FFFF;
      SZ_WORD: size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Low lane-address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_lo_mask(input req_size_t size);
    case (size)
      SZ_BYTE: size_lo_mask = 3'b000;
      SZ_HALF: size_lo_mask = 3'b001;
      SZ_WORD: size_lo_mask = 3'b011;
      default: size_lo_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_201979054_clint_lane_align.sv
// ysyx_201979054_clint_lane_align
//   Combinational byte-lane datapath shared by loads and stores.
//   Ports:
//     rdata      in  64  current CLINT register value
//     wdata      in  64  store data, right-aligned
//     lane       in  3   byte lane of the access
//     size       in  2   access size
//     load_data  out 64  rdata shifted down by lane and masked to size
//     store_data out 64  rdata with the size-masked wdata bytes inserted at lane
module ysyx_201979054_clint_lane_align
  import ysyx_201979054_clint_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  input  logic [2:0]  lane,
  input  req_size_t   size,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [5:0]  shamt;
  logic [63:0] mask;

  always_comb begin
    shamt      = {lane, 3'b000};
    mask       = size_mask(size);
    load_data  = (rdata >> shamt) & mask;
    store_data = (rdata & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/ysyx_201979054_clint_access.sv
// ysyx_201979054_clint_access
//   Bridge from the core load/store path to the CLINT register block.
//   Decodes byte addresses to CLINT word indices, performs read-modify-write
//   for sub-doubleword stores and returns lane-aligned load data.
//   Optional feature macro: CLINT_ACCESS_FAULT_EN (unmapped/misaligned requests
//   answer with o_rsp_err = 1). Without it, unmapped requests are answered
//   silently (load data 0, store dropped) and misaligned lanes are aligned down.
//   Handshake: a transfer happens on a rising clk edge where valid and ready
//   are both high; valid, once raised by the bridge, holds its payload stable
//   until accepted, and ready may be high while valid is low.
//   Ports:
//     clk, arstn                clock, asynchronous active-low reset
//     i_req_valid/o_req_ready   request handshake (ready only in IDLE)
//     i_req_we/addr/size/wdata  request payload
//     o_rsp_valid/i_rsp_ready   response handshake
//     o_rsp_rdata/o_rsp_err     response payload
//     o_clint_we/addr/wdata     CLINT register-block write/address/data
//     i_clint_rdata             CLINT combinational read data for o_clint_addr
//     o_dbg_state               current FSM state
module ysyx_201979054_clint_access
  import ysyx_201979054_clint_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] CLINT_BASE = 32'h0200_0000
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0]            i_req_size,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_clint_we,
  output logic [1:0]            o_clint_addr,
  output logic [DATA_WIDTH-1:0] o_clint_wdata,
  input  logic [DATA_WIDTH-1:0] i_clint_rdata,
  output clint_acc_state_t      o_dbg_state
);

  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("ysyx_201979054_clint_access: DATA_WIDTH must be 64");
  end

  clint_acc_state_t state;

  // Request fields captured on accept.
  logic       we_r;
  logic [2:0] lane_r;
  req_size_t  size_r;
  logic [63:0] wdata_r;

  // Address decode of the incoming request.
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] dw_off;
  logic                  mapped;
  clint_idx_t            req_idx;
  req_size_t             req_size;
  logic [2:0]            lane_fix;
  logic                  req_fault;
  logic                  req_err;

  always_comb begin
    off      = i_req_addr - CLINT_BASE;
    dw_off   = off & ~ADDR_WIDTH'(7);
    req_size = req_size_t'(i_req_size);
    mapped   = 1'b1;
    req_idx  = IDX_MSIP;
    if (dw_off == ADDR_WIDTH'(MSIP_OFF)) begin
      req_idx = IDX_MSIP;
    end else if (dw_off == ADDR_WIDTH'(MTIMECMP_OFF)) begin
      req_idx = IDX_MTIMECMP;
    end else if (dw_off == ADDR_WIDTH'(MTIME_OFF)) begin
      req_idx = IDX_MTIME;
    end else begin
      mapped = 1'b0;
    end
    // Aligned-down lane; equals the raw lane whenever the access is aligned.
    lane_fix = i_req_addr[2:0] & ~size_lo_mask(req_size);
`ifdef CLINT_ACCESS_FAULT_EN
    req_fault = !mapped || (lane_fix != i_req_addr[2:0]);
    req_err   = req_fault;
`else
    req_fault = !mapped;
    req_err   = 1'b0;
`endif
  end

  logic [63:0] load_data;
  logic [63:0] store_data;

  // Read data comes from the register selected by o_clint_addr in ACCESS,
  // so the same instance serves both the load shift and the store merge.
  ysyx_201979054_clint_lane_align u_lane_align (
    .rdata      (i_clint_rdata),
    .wdata      (wdata_r),
    .lane       (lane_r),
    .size       (size_r),
    .load_data  (load_data),
    .store_data (store_data)
  );

  assign o_req_ready = (state == IDLE);
  assign o_dbg_state = state;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= IDLE;
      we_r          <= 1'b0;
      lane_r        <= 3'd0;
      size_r        <= SZ_BYTE;
      wdata_r       <= 64'd0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= 64'd0;
      o_rsp_err     <= 1'b0;
      o_clint_we    <= 1'b0;
      o_clint_addr  <= 2'd0;
      o_clint_wdata <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            we_r    <= i_req_we;
            lane_r  <= lane_fix;
            size_r  <= req_size;
            wdata_r <= i_req_wdata;
            if (req_fault) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= req_err;
              o_rsp_rdata <= 64'd0;
            end else begin
              state        <= ACCESS;
              o_clint_addr <= req_idx;
              // A full-width store needs no read, so it writes in ACCESS.
              if (i_req_we && req_size == SZ_DWORD) begin
                o_clint_we    <= 1'b1;
                o_clint_wdata <= i_req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_r) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= load_data;
          end else if (size_r == SZ_DWORD) begin
            state       <= RESP;
            o_clint_we  <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= 64'd0;
          end else begin
            // The wdata register doubles as the merge register for RMW.
            state         <= WRITE;
            o_clint_we    <= 1'b1;
            o_clint_wdata <= store_data;
          end
        end
        WRITE: begin
          state       <= RESP;
          o_clint_we  <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= 64'd0;
        end
        default: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_201979054_clint_access.sv
module tb_ysyx_201979054_clint_access;
  import ysyx_201979054_clint_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  // clock / reset
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [31:0] i_req_addr = 32'd0;
  logic [1:0]  i_req_size = 2'd0;
  logic [63:0] i_req_wdata = 64'd0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_clint_we;
  logic [1:0]  o_clint_addr;
  logic [63:0] o_clint_wdata;
  logic [63:0] i_clint_rdata;
  clint_acc_state_t o_dbg_state;

  // CLINT register-block stand-in (combinational read)
  logic [63:0] reg_msip = 64'd0;
  logic [63:0] reg_mtime = 64'd0;
  logic [63:0] reg_mtimecmp = 64'd0;

  always_comb begin
    case (o_clint_addr)
      2'd0:    i_clint_rdata = reg_msip;
      2'd1:    i_clint_rdata = reg_mtime;
      2'd2:    i_clint_rdata = reg_mtimecmp;
      default: i_clint_rdata = 64'd0;
    endcase
  end

  ysyx_201979054_clint_access dut (
    .clk           (clk),
    .arstn         (arstn),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_we      (i_req_we),
    .i_req_addr    (i_req_addr),
    .i_req_size    (i_req_size),
    .i_req_wdata   (i_req_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_clint_we    (o_clint_we),
    .o_clint_addr  (o_clint_addr),
    .o_clint_wdata (o_clint_wdata),
    .i_clint_rdata (i_clint_rdata),
    .o_dbg_state   (o_dbg_state)
  );

  int total = 0;
  int bad = 0;

  // per-transaction observations
  int          lat;
  int          we_cnt;
  int          we_lat;
  logic [1:0]  we_addr;
  logic [63:0] we_wdata;
  logic [1:0]  acc_addr;
  logic [63:0] held_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample_we();
    if (o_clint_we) begin
      we_cnt++;
      we_lat   = lat;
      we_addr  = o_clint_addr;
      we_wdata = o_clint_wdata;
    end
  endtask

  // Drive one request and step until the response appears (bounded).
  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic [63:0] wdata);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_size  = size;
    i_req_wdata = wdata;
    @(negedge clk);
    i_req_valid = 1'b0;
    lat = 1; we_cnt = 0; we_lat = 0; we_addr = 2'd0; we_wdata = 64'd0;
    acc_addr = o_clint_addr;
    sample_we();
    while (!o_rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
      sample_we();
    end
    chk("rsp_valid_seen", 64'(o_rsp_valid), 64'd1);
  endtask

  task automatic finish_rsp(input string tag);
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    chk({tag, "_ready_after"}, 64'(o_req_ready), 64'd1);
    chk({tag, "_valid_after"}, 64'(o_rsp_valid), 64'd0);
  endtask

  initial begin
    // reset state
    reg_msip     = 64'h1122_3344_5566_7788;
    reg_mtime    = 64'h0000_0005_0000_0009;
    reg_mtimecmp = 64'h1122_3344_5566_7788;
    #12;
    chk("rst_ready",  64'(o_req_ready), 64'd1);
    chk("rst_valid",  64'(o_rsp_valid), 64'd0);
    chk("rst_err",    64'(o_rsp_err), 64'd0);
    chk("rst_we",     64'(o_clint_we), 64'd0);
    chk("rst_rdata",  o_rsp_rdata, 64'd0);
    chk("rst_addr",   64'(o_clint_addr), 64'd0);
    chk("rst_wdata",  o_clint_wdata, 64'd0);
    chk("rst_state",  64'(o_dbg_state), 64'(IDLE));
    @(negedge clk);
    arstn = 1'b1;

    // 1: dword store to MTIMECMP
    do_req(1'b1, BASE + 32'h4000, 2'd3, 64'h0000_0000_0000_1000);
    chk("t1_lat",    64'(lat), 64'd2);
    chk("t1_we_cnt", 64'(we_cnt), 64'd1);
    chk("t1_we_lat", 64'(we_lat), 64'd1);
    chk("t1_addr",   64'(we_addr), 64'd2);
    chk("t1_wdata",  we_wdata, 64'h1000);
    chk("t1_err",    64'(o_rsp_err), 64'd0);
    chk("t1_rdata",  o_rsp_rdata, 64'd0);
    finish_rsp("t1");

    // 2: word load from upper half of MTIME
    do_req(1'b0, BASE + 32'hBFFC, 2'd2, 64'd0);
    chk("t2_lat",   64'(lat), 64'd2);
    chk("t2_addr",  64'(acc_addr), 64'd1);
    chk("t2_no_we", 64'(we_cnt), 64'd0);
    chk("t2_rdata", o_rsp_rdata, 64'h0000_0000_0000_0005);
    chk("t2_err",   64'(o_rsp_err), 64'd0);
    finish_rsp("t2");

    // 3: byte store into MSIP = 0 (read-modify-write)
    reg_msip = 64'd0;
    do_req(1'b1, BASE + 32'h0002, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB);
    chk("t3_lat",    64'(lat), 64'd3);
    chk("t3_we_cnt", 64'(we_cnt), 64'd1);
    chk("t3_we_lat", 64'(we_lat), 64'd2);
    chk("t3_addr",   64'(we_addr), 64'd0);
    chk("t3_wdata",  we_wdata, 64'h0000_0000_00AB_0000);
    finish_rsp("t3");

    // 3b: half store merged into top lane of MTIMECMP
    do_req(1'b1, BASE + 32'h4006, 2'd1, 64'h0000_0000_0000_BEEF);
    chk("t3b_lat",   64'(lat), 64'd3);
    chk("t3b_addr",  64'(we_addr), 64'd2);
    chk("t3b_wdata", we_wdata, 64'hBEEF_3344_5566_7788);
    finish_rsp("t3b");

    // 3c: byte load from lane 3 of MSIP, dword load from MTIME
    reg_msip = 64'h1122_3344_5566_7788;
    do_req(1'b0, BASE + 32'h0003, 2'd0, 64'd0);
    chk("t3c_rdata", o_rsp_rdata, 64'h55);
    finish_rsp("t3c");
    do_req(1'b0, BASE + 32'hBFF8, 2'd3, 64'd0);
    chk("t3d_rdata", o_rsp_rdata, 64'h0000_0005_0000_0009);
    finish_rsp("t3d");

    // 4: back-pressure on a word load from MTIMECMP
    do_req(1'b0, BASE + 32'h4000, 2'd2, 64'd0);
    chk("t4_rdata", o_rsp_rdata, 64'h5566_7788);
    held_rdata = o_rsp_rdata;
    i_req_valid = 1'b1;      // must be ignored while a response is pending
    i_req_we    = 1'b1;
    i_req_size  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid_hold", 64'(o_rsp_valid), 64'd1);
      chk("t4_rdata_hold", o_rsp_rdata, 64'h5566_7788);
      chk("t4_req_ready",  64'(o_req_ready), 64'd0);
      chk("t4_no_we",      64'(o_clint_we), 64'd0);
    end
    i_req_valid = 1'b0;
    finish_rsp("t4");

    // 5: misaligned half load and unmapped store
    do_req(1'b0, BASE + 32'h0001, 2'd1, 64'd0);
    chk("t5a_no_we", 64'(we_cnt), 64'd0);
`ifdef CLINT_ACCESS_FAULT_EN
    chk("t5a_err",   64'(o_rsp_err), 64'd1);
    chk("t5a_lat",   64'(lat), 64'd1);
    chk("t5a_rdata", o_rsp_rdata, 64'd0);
`else
    chk("t5a_err",   64'(o_rsp_err), 64'd0);
    chk("t5a_lat",   64'(lat), 64'd2);
    chk("t5a_rdata", o_rsp_rdata, 64'h7788);
`endif
    finish_rsp("t5a");

    do_req(1'b1, BASE + 32'h1000, 2'd3, 64'h1234);
    chk("t5b_no_we", 64'(we_cnt), 64'd0);
    chk("t5b_lat",   64'(lat), 64'd1);
`ifdef CLINT_ACCESS_FAULT_EN
    chk("t5b_err",   64'(o_rsp_err), 64'd1);
`else
    chk("t5b_err",   64'(o_rsp_err), 64'd0);
`endif
    finish_rsp("t5b");

    // unmapped load answers with zero data
    do_req(1'b0, BASE + 32'h8000, 2'd3, 64'd0);
    chk("t5c_lat",   64'(lat), 64'd1);
    chk("t5c_rdata", o_rsp_rdata, 64'd0);
    finish_rsp("t5c");

    // misaligned word store at lane 5
    do_req(1'b1, BASE + 32'h4005, 2'd2, 64'h0000_0000_DEAD_BEEF);
`ifdef CLINT_ACCESS_FAULT_EN
    chk("t5d_err",   64'(o_rsp_err), 64'd1);
    chk("t5d_no_we", 64'(we_cnt), 64'd0);
`else
    chk("t5d_lat",   64'(lat), 64'd3);
    chk("t5d_wdata", we_wdata, 64'hDEAD_BEEF_5566_7788);
`endif
    finish_rsp("t5d");

    // 6: reset asserted during WRITE
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = BASE + 32'h4001;
    i_req_size  = 2'd0;
    i_req_wdata = 64'h5A;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    chk("t6_we_in_write", 64'(o_clint_we), 64'd1);
    chk("t6_state_write", 64'(o_dbg_state), 64'(WRITE));
    arstn = 1'b0;
    #1;
    chk("t6_we_dropped", 64'(o_clint_we), 64'd0);
    chk("t6_state_idle", 64'(o_dbg_state), 64'(IDLE));
    chk("t6_no_rsp",     64'(o_rsp_valid), 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_ready_after", 64'(o_req_ready), 64'd1);
      chk("t6_rsp_dropped", 64'(o_rsp_valid), 64'd0);
    end

    // recovery: normal load after reset
    do_req(1'b0, BASE + 32'hBFF8, 2'd2, 64'd0);
    chk("t7_rdata", o_rsp_rdata, 64'h9);
    finish_rsp("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
